// File: rtl/reg_file.sv
// Single-write, single-read register file: synchronous write, combinational read,
// synchronous active-low clear of every entry.
module reg_file #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic [WIDTH-1:0]      dIn,
  input  logic [ADDR_WIDTH-1:0] writeAddr,
  input  logic                  writeEnable,
  input  logic [ADDR_WIDTH-1:0] readAddr,
  output logic [WIDTH-1:0]      dOut
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];

  always_comb begin
    regs_d = regs_q;
    if (writeEnable) begin
      regs_d[writeAddr] = dIn;
    end
  end

  // Reset takes priority over a same-cycle write.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // No write-to-read bypass: the read sees stored contents only.
  assign dOut = regs_q[readAddr];

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: the driver pushes expected read data, a negedge
// monitor pops and compares against dOut.
module tb_reg_file;

  localparam int unsigned W  = 8;
  localparam int unsigned AW = 2;
  localparam int unsigned D  = 4;

  logic          clk = 1'b0;
  logic          rstN;
  logic [W-1:0]  dIn;
  logic [AW-1:0] writeAddr;
  logic          writeEnable;
  logic [AW-1:0] readAddr;
  logic [W-1:0]  dOut;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  int compared   = 0;
  int mismatched = 0;

  // Reference contents of the register file; model_valid is cleared until the first reset.
  int unsigned model [D];
  bit          model_valid = 1'b0;

  reg_file #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rstN       (rstN),
    .dIn        (dIn),
    .writeAddr  (writeAddr),
    .writeEnable(writeEnable),
    .readAddr   (readAddr),
    .dOut       (dOut)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_entry_t e;
      e = sb.pop_front();
      compared++;
      if (dOut !== e.exp) begin
        mismatched++;
        $display("FAIL %s: readAddr=%0d dOut=%02h expected=%02h", e.name, readAddr, dOut, e.exp);
      end
    end
  end

  // Apply one cycle of stimulus; expectation is the pre-edge contents, then the model steps.
  task automatic step(input string nm, input bit rn, input bit we,
                      input int unsigned wa, input int unsigned din, input int unsigned ra);
    sb_entry_t e;
    rstN        = rn;
    writeEnable = we;
    writeAddr   = AW'(wa);
    dIn         = W'(din);
    readAddr    = AW'(ra);
    if (model_valid) begin
      e.name = nm;
      e.exp  = 8'(model[ra]);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!rn) begin
      foreach (model[i]) model[i] = 0;
      model_valid = 1'b1;
    end else if (we) begin
      model[wa] = din & 8'hFF;
    end
  endtask

  task automatic read_all(input string nm, input bit descending);
    for (int k = 0; k < int'(D); k++) begin
      step(nm, 1'b1, 1'b0, 0, 0, descending ? (D - 1 - k) : k);
    end
  endtask

  initial begin
    rstN = 1'b1; writeEnable = 1'b0; writeAddr = '0; dIn = '0; readAddr = '0;
    @(posedge clk); #1;

    step("reset", 1'b0, 1'b0, 0, 0, 0);
    read_all("after_reset", 1'b0);

    for (int i = 0; i < 4; i++) step("asc_fill", 1'b1, 1'b1, i, i, i);
    read_all("asc_read", 1'b0);

    for (int i = 3; i >= 0; i--) step("desc_fill", 1'b1, 1'b1, i, (~i) & 8'hFF, i);
    read_all("desc_read", 1'b1);

    for (int i = 0; i < 4; i++) step("refill", 1'b1, 1'b1, i, i, 0);
    read_all("refill_read", 1'b0);

    for (int i = 0; i < 4; i++) step("fill_5a", 1'b1, 1'b1, i, 8'h5A, 0);
    for (int n = 0; n < 4; n++) step("we_low", 1'b1, 1'b0, 2, 8'hA5, 2);
    step("we_low_final", 1'b1, 1'b0, 0, 0, 2);

    step("set_11", 1'b1, 1'b1, 1, 8'h11, 1);
    step("bypass_before", 1'b1, 1'b1, 1, 8'h22, 1);
    step("bypass_after", 1'b1, 1'b0, 0, 0, 1);

    step("back_to_back_a", 1'b1, 1'b1, 3, 8'h31, 3);
    step("back_to_back_b", 1'b1, 1'b1, 3, 8'h32, 3);
    step("back_to_back_rd", 1'b1, 1'b0, 0, 0, 3);

    for (int i = 0; i < 4; i++) step("pre_rst_fill", 1'b1, 1'b1, i, i, 0);
    step("rst_vs_write", 1'b0, 1'b1, 3, 8'h77, 3);
    read_all("post_rst_read", 1'b0);

    for (int n = 0; n < 400; n++) begin
      step("random", ($urandom_range(0, 19) != 0), $urandom_range(0, 1),
           $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 3));
    end
    read_all("final_read", 1'b0);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
